// File: rtl/uart_loader_pkg.sv
// Shared command/response codes, command FSM states and baud divider helper
// for the UART program loader.
package uart_loader_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_HOLD = 8'h48;

    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        CMD_ARGS,
        MEM_WR,
        MEM_RD,
        RD_WAIT,
        SEND,
        DONE
    } state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid
// on a good stop bit, one-cycle frame_err on a bad one.
module uart_rx_byte #(
    parameter int DIV = 16
) (
    input  logic       clk_xtal,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        st;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            st         <= RX_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cnt <= HALF;
                        st  <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_sync) begin
                        st <= RX_IDLE;                 // glitch, not a start bit
                    end else begin
                        cnt     <= FULL;
                        bit_idx <= '0;
                        st      <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) st <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            data       <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        st <= RX_IDLE;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_loader.sv
// UART command responder: host writes/reads program memory and releases or
// holds the CPU reset; responses are serialized back on tx.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              clk_xtal,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              frame_err
);
    localparam int DIV    = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W  = $clog2(DIV);
    localparam int TOUT   = TIMEOUT_BITS * DIV;
    localparam int TOUT_W = $clog2(TOUT + 1);

    logic       byte_valid;
    logic [7:0] rx_data;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk_xtal   (clk_xtal),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .data       (rx_data),
        .frame_err  (frame_err)
    );

    logic             tx_start, tx_busy;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_left;
    logic [8:0]       tx_frame;

    // Frame is start bit driven immediately, then 8 data bits and the stop bit.
    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_left  <= '0;
            tx_frame <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                tx_frame <= {1'b1, tx_data};
                tx_left  <= 4'd9;
                tx_cnt   <= CNT_W'(DIV - 1);
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else if (tx_left == '0) begin
            tx_busy <= 1'b0;
        end else begin
            tx       <= tx_frame[0];
            tx_frame <= {1'b1, tx_frame[8:1]};
            tx_left  <= tx_left - 1'b1;
            tx_cnt   <= CNT_W'(DIV - 1);
        end
    end

    state_t            state;
    logic [7:0]        cmd;
    logic [31:0]       args;
    logic [31:0]       args_next;
    logic [2:0]        arg_left;
    logic [TOUT_W-1:0] tout_cnt;
    logic [15:0]       rsp;
    logic [1:0]        rsp_cnt;

    assign args_next = {args[23:0], rx_data};

    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd       <= '0;
            args      <= '0;
            arg_left  <= '0;
            tout_cnt  <= '0;
            rsp       <= '0;
            rsp_cnt   <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        cmd      <= rx_data;
                        tout_cnt <= TOUT_W'(TOUT - 1);
                        rsp      <= {RSP_ACK, 8'h00};
                        rsp_cnt  <= 2'd1;
                        case (rx_data)
                            CMD_WR: begin arg_left <= 3'd4; state <= CMD_ARGS; end
                            CMD_RD: begin arg_left <= 3'd2; state <= CMD_ARGS; end
                            CMD_GO: begin cpu_hold <= 1'b0; state <= SEND; end
                            CMD_HOLD: begin cpu_hold <= 1'b1; state <= SEND; end
                            default: begin
                                rsp   <= {RSP_NAK, 8'h00};
                                state <= SEND;
                            end
                        endcase
                    end
                end
                CMD_ARGS: begin
                    if (byte_valid) begin
                        args     <= args_next;
                        arg_left <= arg_left - 1'b1;
                        tout_cnt <= TOUT_W'(TOUT - 1);
                        if (arg_left == 3'd1) begin
                            if (cmd == CMD_WR) begin
                                mem_addr  <= ADDR_W'(args_next[31:16]);
                                mem_wdata <= args_next[15:0];
                                mem_we    <= 1'b1;
                                state     <= MEM_WR;
                            end else begin
                                mem_addr <= ADDR_W'(args_next[15:0]);
                                mem_re   <= 1'b1;
                                state    <= MEM_RD;
                            end
                        end
                    end else if (tout_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        tout_cnt <= tout_cnt - 1'b1;
                    end
                end
                MEM_WR: begin
                    mem_we  <= 1'b0;
                    rsp     <= {RSP_ACK, 8'h00};
                    rsp_cnt <= 2'd1;
                    state   <= SEND;
                end
                MEM_RD: begin
                    mem_re <= 1'b0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp     <= mem_rdata;
                    rsp_cnt <= 2'd2;
                    state   <= SEND;
                end
                SEND: begin
                    // tx_start is checked too: tx_busy rises one cycle after it.
                    if (!tx_busy && !tx_start) begin
                        if (rsp_cnt == '0) begin
                            state <= DONE;
                        end else begin
                            tx_start <= 1'b1;
                            tx_data  <= rsp[15:8];
                            rsp      <= {rsp[7:0], 8'h00};
                            rsp_cnt  <= rsp_cnt - 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader at DIV=16: serial host driver, tx decoder,
// and a small synchronous memory model.
module tb_uart_loader;
    import uart_loader_pkg::*;

    logic        clk_xtal = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        cpu_hold;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_loader #(
        .CLK_HZ(1600000), .BAUD(100000), .ADDR_W(16), .DATA_W(16), .TIMEOUT_BITS(64)
    ) dut (
        .clk_xtal  (clk_xtal),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .frame_err (frame_err)
    );

    always #5 clk_xtal = ~clk_xtal;

    int          we_cnt = 0, re_cnt = 0, fe_cnt = 0;
    logic [15:0] we_addr = '0, we_data = '0, re_addr = '0;

    always @(posedge clk_xtal) begin
        if (mem_re) mem_rdata <= (mem_addr == 16'h0010) ? 16'hBEEF : (mem_addr ^ 16'h5A5A);
        if (mem_we) begin we_cnt <= we_cnt + 1; we_addr <= mem_addr; we_data <= mem_wdata; end
        if (mem_re) begin re_cnt <= re_cnt + 1; re_addr <= mem_addr; end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    // tx decoder: bytes land in a ring, the bench consumes from rd_ptr.
    logic [7:0] rsp_mem [256];
    int         rsp_wr = 0;
    int         rd_ptr = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (8) @(posedge clk_xtal);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(posedge clk_xtal);
                b[i] = tx;
            end
            repeat (16) @(posedge clk_xtal);
            rsp_mem[rsp_wr % 256] = b;
            rsp_wr = rsp_wr + 1;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
        @(negedge clk_xtal) rx = 1'b0;
        repeat (16) @(negedge clk_xtal);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk_xtal);
        end
        rx = stop;
        repeat (16) @(negedge clk_xtal);
        rx = 1'b1;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while ((rsp_wr - rd_ptr) < n && k < 3000) begin
            @(negedge clk_xtal);
            k++;
        end
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b = rsp_mem[rd_ptr % 256];
        rd_ptr = rd_ptr + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk_xtal);
        n_checks++;
        if ({tx, mem_we, mem_re, cpu_hold, frame_err} !== 5'b10010) begin
            n_fail++;
            $display("FAIL reset_ctrl: tx/we/re/hold/ferr=%b required 10010",
                     {tx, mem_we, mem_re, cpu_hold, frame_err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr/wdata=%h required 00000000", {mem_addr, mem_wdata});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_xtal);
    endtask

    task automatic test_write();
        int we0 = we_cnt, re0 = re_cnt;
        logic [7:0] b;
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        wait_rsp(1);
        n_checks++;
        if ((rsp_wr - rd_ptr) != 1) begin
            n_fail++;
            $display("FAIL wr_rsp_count: got %0d bytes, required 1", rsp_wr - rd_ptr);
        end else begin
            pop_byte(b);
            n_checks++;
            if (b !== 8'h06) begin n_fail++; $display("FAIL wr_ack: got %h, required 06", b); end
        end
        n_checks++;
        if (we_cnt - we0 != 1 || re_cnt != re0) begin
            n_fail++;
            $display("FAIL wr_strobes: we=%0d re=%0d, required we=1 re=0", we_cnt - we0, re_cnt - re0);
        end
        n_checks++;
        if (we_addr !== 16'h1234 || we_data !== 16'hABCD) begin
            n_fail++;
            $display("FAIL wr_bus: addr=%h data=%h, required 1234 ABCD", we_addr, we_data);
        end
        n_checks++;
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL wr_hold: got %b, required 1", cpu_hold); end
    endtask

    task automatic test_read();
        int re0 = re_cnt, we0 = we_cnt;
        logic [7:0] b0, b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_rsp(2);
        n_checks++;
        if ((rsp_wr - rd_ptr) != 2) begin
            n_fail++;
            $display("FAIL rd_rsp_count: got %0d bytes, required 2", rsp_wr - rd_ptr);
        end else begin
            pop_byte(b0); pop_byte(b1);
            n_checks++;
            if ({b0, b1} !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL rd_data: got %h %h, required BE EF", b0, b1);
            end
        end
        n_checks++;
        if (re_cnt - re0 != 1 || re_addr !== 16'h0010 || we_cnt != we0) begin
            n_fail++;
            $display("FAIL rd_strobe: re=%0d addr=%h we=%0d, required re=1 addr=0010 we=0",
                     re_cnt - re0, re_addr, we_cnt - we0);
        end
    endtask

    task automatic test_cmd_go();
        int we0 = we_cnt, re0 = re_cnt;
        logic [7:0] b;
        send_byte(8'h99);
        wait_rsp(1);
        pop_byte(b);
        n_checks++;
        if (b !== 8'h15) begin n_fail++; $display("FAIL bad_cmd_nak: got %h, required 15", b); end
        n_checks++;
        if (we_cnt != we0 || re_cnt != re0) begin
            n_fail++;
            $display("FAIL bad_cmd_strobes: we=%0d re=%0d, required 0 0", we_cnt - we0, re_cnt - re0);
        end
        n_checks++;
        if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL go_pre_hold: got %b, required 1", cpu_hold); end
        send_byte(8'h47);
        repeat (2) @(negedge clk_xtal);
        n_checks++;
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL go_hold: got %b, required 0", cpu_hold); end
        wait_rsp(1);
        pop_byte(b);
        n_checks++;
        if (b !== 8'h06) begin n_fail++; $display("FAIL go_ack: got %h, required 06", b); end
        send_byte(8'h47);
        wait_rsp(1);
        pop_byte(b);
        n_checks++;
        if (b !== 8'h06 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL go_again: ack=%h hold=%b, required 06 0", b, cpu_hold);
        end
        send_byte(8'h48);
        wait_rsp(1);
        pop_byte(b);
        n_checks++;
        if (b !== 8'h06 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ack: ack=%h hold=%b, required 06 1", b, cpu_hold);
        end
    endtask

    task automatic test_framing();
        int fe0 = fe_cnt;
        send_byte(8'h57, 1'b0);
        repeat (400) @(negedge clk_xtal);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d, required 1", fe_cnt - fe0); end
        n_checks++;
        if ((rsp_wr - rd_ptr) != 0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL frame_err_drop: rsp=%0d state=%0d, required 0 IDLE", rsp_wr - rd_ptr, dut.state);
        end
        @(negedge clk_xtal) rx = 1'b0;
        repeat (4) @(negedge clk_xtal);
        rx = 1'b1;
        repeat (400) @(negedge clk_xtal);
        n_checks++;
        if ((rsp_wr - rd_ptr) != 0 || fe_cnt - fe0 != 1 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL glitch: rsp=%0d ferr=%0d state=%0d, required 0 1 IDLE",
                     rsp_wr - rd_ptr, fe_cnt - fe0, dut.state);
        end
    endtask

    task automatic test_timeout();
        int we0 = we_cnt, re0 = re_cnt;
        logic [7:0] b0, b1;
        send_byte(8'h57); send_byte(8'h12);
        repeat (64 * 16 + 1) @(negedge clk_xtal);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        wait_rsp(2);
        n_checks++;
        if ((rsp_wr - rd_ptr) != 2) begin
            n_fail++;
            $display("FAIL tout_rsp_count: got %0d bytes, required 2", rsp_wr - rd_ptr);
        end else begin
            pop_byte(b0); pop_byte(b1);
            n_checks++;
            if ({b0, b1} !== 16'h5A5B) begin
                n_fail++;
                $display("FAIL tout_rd_data: got %h %h, required 5A 5B", b0, b1);
            end
        end
        n_checks++;
        if (we_cnt != we0 || re_cnt - re0 != 1 || re_addr !== 16'h0001) begin
            n_fail++;
            $display("FAIL tout_strobes: we=%0d re=%0d addr=%h, required 0 1 0001",
                     we_cnt - we0, re_cnt - re0, re_addr);
        end
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int we0;
        logic [7:0] b;
        send_byte(8'h47);
        wait_rsp(1);
        pop_byte(b);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        while (tx !== 1'b0 && k < 500) begin @(negedge clk_xtal); k++; end
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: tx=%b, required 0", tx); end
        repeat (80) @(negedge clk_xtal);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || cpu_hold !== 1'b1 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_mid: tx=%b hold=%b state=%0d, required 1 1 IDLE", tx, cpu_hold, dut.state);
        end
        repeat (3) @(negedge clk_xtal);
        rst_n = 1'b1;
        repeat (300) @(negedge clk_xtal);
        rd_ptr = rsp_wr;
        we0 = we_cnt;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h55); send_byte(8'hAA);
        wait_rsp(1);
        n_checks++;
        if ((rsp_wr - rd_ptr) != 1) begin
            n_fail++;
            $display("FAIL post_rst_count: got %0d bytes, required 1", rsp_wr - rd_ptr);
        end else begin
            pop_byte(b);
            n_checks++;
            if (b !== 8'h06) begin n_fail++; $display("FAIL post_rst_ack: got %h, required 06", b); end
        end
        n_checks++;
        if (we_cnt - we0 != 1 || we_addr !== 16'h0020 || we_data !== 16'h55AA) begin
            n_fail++;
            $display("FAIL post_rst_wr: we=%0d addr=%h data=%h, required 1 0020 55AA",
                     we_cnt - we0, we_addr, we_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_cmd_go();
        test_framing();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
